// File: rtl/down_count_pkg.sv
// rtl/down_count_pkg.sv - shared types for the down-count timer
// Contents: state_t (IDLE/RUN/DONE, 2 bits), DEFAULT_WIDTH.
package down_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/down_step_sat.sv
// rtl/down_step_sat.sv - combinational saturating decrement toward a terminal value
// Ports:
//   i_counter     current count
//   i_end         terminal value (never above i_counter in normal use)
//   i_step        decrement amount (already forced non-zero by the caller)
//   o_next        count after one step, clamped at i_end; equals i_counter at terminal
//   o_is_terminal i_counter == i_end
module down_step_sat #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_counter,
    input  logic [WIDTH-1:0] i_end,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_next,
    output logic             o_is_terminal
);

    logic [WIDTH-1:0] w_gap;

    // Distance still to travel; comparing it against the step avoids
    // ever computing a value that wraps below i_end.
    assign w_gap         = i_counter - i_end;
    assign o_is_terminal = (i_counter == i_end);

    always_comb begin
        o_next = i_counter;
        if (!o_is_terminal) begin
            if (w_gap < i_step) begin
                o_next = i_end;
            end else begin
                o_next = i_counter - i_step;
            end
        end
    end

endmodule

// File: rtl/down_count_timer.sv
// rtl/down_count_timer.sv - programmable down-counter/timer with one-shot or auto-reload
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   load_valid/ready    load handshake (ready only in IDLE and not aborting)
//   load_start/end/step start, terminal and decrement values; step 0 acts as 1
//   load_reload         1 = reload start at terminal, 0 = stop
//   en                  count enable; abort returns to IDLE
//   counter, counter_f  registered count and its combinational next value
//   at_end, done, busy  terminal reached in RUN, terminal pulse, not IDLE
module down_count_timer
    import down_count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_start,
    input  logic [WIDTH-1:0] load_end,
    input  logic [WIDTH-1:0] load_step,
    input  logic             load_reload,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] counter_f,
    output logic             at_end,
    output logic             done,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] start_val;
        logic [WIDTH-1:0] end_val;
        logic [WIDTH-1:0] step_val;
        logic             reload;
    } load_cfg_t;

    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    load_cfg_t        r_cfg;
    load_cfg_t        w_cfg_in;
    logic [WIDTH-1:0] r_counter;
    logic             r_done;

    logic             w_load_ready;
    logic             w_accept;
    logic             w_count_en;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_step_next;
    logic             w_terminal;
    logic [WIDTH-1:0] w_counter_f;

    down_step_sat #(.WIDTH(WIDTH)) u_step (
        .i_counter     (r_counter),
        .i_end         (r_cfg.end_val),
        .i_step        (r_cfg.step_val),
        .o_next        (w_step_next),
        .o_is_terminal (w_terminal)
    );

    // A start below end is clamped up so reloads never land beneath end.
    always_comb begin
        w_cfg_in.start_val = (load_start < load_end) ? load_end : load_start;
        w_cfg_in.end_val   = load_end;
        w_cfg_in.step_val  = (load_step == '0) ? STEP_ONE : load_step;
        w_cfg_in.reload    = load_reload;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_accept     = 1'b0;
        w_count_en   = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort in IDLE outranks a load
                w_load_ready = ~abort;
                if (load_valid && !abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort also suppresses a same-cycle terminal event
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (en) begin
                    w_count_en = 1'b1;
                    if (w_terminal) begin
                        w_done_nxt = 1'b1;
                        if (!r_cfg.reload) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_counter_f = r_counter;
        if (r_state == ST_RUN && en) begin
            if (w_terminal) begin
                w_counter_f = r_cfg.reload ? r_cfg.start_val : r_counter;
            end else begin
                w_counter_f = w_step_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cfg     <= '0;
            r_counter <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_cfg     <= w_cfg_in;
                r_counter <= w_cfg_in.start_val;
            end else if (w_count_en) begin
                r_counter <= w_counter_f;
            end
        end
    end

    assign load_ready = w_load_ready;
    assign counter    = r_counter;
    assign counter_f  = w_counter_f;
    assign at_end     = (r_state == ST_RUN) && w_terminal;
    assign done       = r_done;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_down_count_timer.sv
// tb/tb_down_count_timer.sv - self-checking bench for down_count_timer
module tb_down_count_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_start;
    logic [7:0] load_end;
    logic [7:0] load_step;
    logic       load_reload;
    logic       en;
    logic       abort;
    logic [7:0] counter;
    logic [7:0] counter_f;
    logic       at_end;
    logic       done;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    down_count_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_start  (load_start),
        .load_end    (load_end),
        .load_step   (load_step),
        .load_reload (load_reload),
        .en          (en),
        .abort       (abort),
        .counter     (counter),
        .counter_f   (counter_f),
        .at_end      (at_end),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic [7:0] st;
        logic [7:0] ed;
        logic [7:0] sp;
        logic       rl;
        logic       en;
        logic       ab;
        logic [7:0] cnt;
        logic       dn;
        logic       by;
        logic       ae;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int lv, input int st, input int ed, input int sp,
                           input int rl, input int e, input int ab,
                           input int cnt, input int dn, input int by, input int ae);
        vec_t v;
        v.lv = 1'(lv); v.st = 8'(st); v.ed = 8'(ed); v.sp = 8'(sp);
        v.rl = 1'(rl); v.en = 1'(e); v.ab = 1'(ab);
        v.cnt = 8'(cnt); v.dn = 1'(dn); v.by = 1'(by); v.ae = 1'(ae);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int st, input int ed, input int sp, input int rl);
        load_valid = 1'b1; load_start = 8'(st); load_end = 8'(ed);
        load_step = 8'(sp); load_reload = 1'(rl);
        tick();
        load_valid = 1'b0;
    endtask

    // Reference model: a load expands into the full list of count values
    // from start down to end; RUN walks an index through that list.
    int m_phase;   // 0 idle, 1 run, 2 done
    int m_seq[$];
    int m_idx;
    int m_cnt;
    int m_done;
    int m_reload;

    task automatic model_reset();
        m_phase = 0; m_seq.delete(); m_idx = 0; m_cnt = 0; m_done = 0; m_reload = 0;
    endtask

    function automatic int m_last();
        return m_seq.size() - 1;
    endfunction

    function automatic int model_cf();
        if (m_phase == 1 && en) begin
            if (m_idx == m_last()) return (m_reload != 0) ? m_seq[0] : m_cnt;
            return m_seq[m_idx + 1];
        end
        return m_cnt;
    endfunction

    task automatic model_edge();
        int s, e, st;
        m_done = 0;
        case (m_phase)
            0: if (load_valid && !abort) begin
                e  = int'(load_end);
                s  = (int'(load_start) > e) ? int'(load_start) : e;
                st = (load_step == 8'd0) ? 1 : int'(load_step);
                m_seq.delete();
                m_seq.push_back(s);
                while (s > e) begin
                    s = s - st;
                    if (s < e) s = e;
                    m_seq.push_back(s);
                end
                m_reload = int'(load_reload);
                m_idx = 0; m_cnt = m_seq[0]; m_phase = 1;
            end
            1: if (abort) begin
                m_phase = 0;
            end else if (en) begin
                if (m_idx == m_last()) begin
                    m_done = 1;
                    if (m_reload != 0) begin m_idx = 0; m_cnt = m_seq[0]; end
                    else m_phase = 2;
                end else begin
                    m_idx++; m_cnt = m_seq[m_idx];
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    initial begin
        int ar_exp[12] = '{3, 1, 0, 5, 3, 1, 0, 5, 3, 1, 0, 5};
        int n_en;
        int saw_done;

        rst = 1'b0; load_valid = 1'b0; load_start = '0; load_end = '0;
        load_step = '0; load_reload = 1'b0; en = 1'b0; abort = 1'b0;
        #12;
        check("rst_counter", int'(counter), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(load_ready), 1);
        check("rst_at_end", int'(at_end), 0);
        @(negedge clk); rst = 1'b1;

        //      lv st  ed sp rl en ab  cnt dn by ae
        add_vec(1, 10, 2, 3, 0, 1, 0,  10, 0, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   7, 0, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   4, 0, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   2, 0, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 0,   2, 1, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   2, 0, 0, 0);
        add_vec(1, 2,  0, 0, 0, 1, 0,   2, 0, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   1, 0, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   0, 0, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 0,   0, 1, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);
        add_vec(1, 3,  9, 1, 0, 1, 0,   9, 0, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 0,   9, 1, 1, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0,   9, 0, 0, 0);
        add_vec(1, 5,  5, 1, 1, 1, 0,   5, 0, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 0,   5, 1, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 0,   5, 1, 1, 1);
        add_vec(0, 0,  0, 0, 0, 0, 0,   5, 0, 1, 1);
        add_vec(0, 0,  0, 0, 0, 1, 1,   5, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            load_valid = tbl[i].lv; load_start = tbl[i].st; load_end = tbl[i].ed;
            load_step = tbl[i].sp; load_reload = tbl[i].rl; en = tbl[i].en; abort = tbl[i].ab;
            tick();
            load_valid = 1'b0; abort = 1'b0;
            #1;
            check($sformatf("vec%0d_counter", i), int'(counter), int'(tbl[i].cnt));
            check($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].dn));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].by));
            check($sformatf("vec%0d_at_end", i), int'(at_end), int'(tbl[i].ae));
            check($sformatf("vec%0d_ready", i), int'(load_ready), int'(!tbl[i].by));
        end

        // auto-reload 5 -> 0 by 2
        en = 1'b1;
        do_load(5, 0, 2, 1);
        check("ar_start", int'(counter), 5);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("ar_cnt%0d", k), int'(counter), ar_exp[k]);
            check($sformatf("ar_done%0d", k), int'(done), (ar_exp[k] == 5) ? 1 : 0);
            check($sformatf("ar_busy%0d", k), int'(busy), 1);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        check("ar_abort_busy", int'(busy), 0);

        // pause: en low for cycles 2..4
        do_load(4, 0, 1, 0);
        n_en = 0; saw_done = 0;
        for (int c = 1; c <= 20; c++) begin
            en = !(c >= 2 && c <= 4);
            if (en) n_en++;
            tick();
            if (c >= 2 && c <= 4) check($sformatf("pause_hold%0d", c), int'(counter), 3);
            if (done) begin saw_done = 1; break; end
        end
        check("pause_done_seen", saw_done, 1);
        check("pause_enabled_cycles", n_en, 5);
        en = 1'b1; tick();

        // load while busy is ignored
        do_load(8, 0, 1, 0);
        en = 1'b0;
        load_valid = 1'b1; load_start = 8'd50; load_end = 8'd20; load_step = 8'd4; load_reload = 1'b1;
        #1;
        check("busy_ready_low", int'(load_ready), 0);
        tick();
        check("busy_load_cnt", int'(counter), 8);
        load_valid = 1'b0; en = 1'b1;
        tick();
        check("busy_load_step", int'(counter), 7);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_run_busy", int'(busy), 0);
        check("abort_run_cnt", int'(counter), 7);
        check("abort_run_done", int'(done), 0);

        // abort with load in IDLE
        abort = 1'b1; load_valid = 1'b1; load_start = 8'd9; load_end = 8'd0; load_step = 8'd1;
        #1;
        check("idle_abort_ready", int'(load_ready), 0);
        tick();
        abort = 1'b0; load_valid = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_cnt", int'(counter), 7);

        // asynchronous reset mid-RUN
        do_load(200, 0, 1, 0);
        tick(); tick(); tick();
        check("pre_reset_cnt", int'(counter), 197);
        #2; rst = 1'b0; #1;
        check("areset_cnt", int'(counter), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_done", int'(done), 0);
        check("areset_ready", int'(load_ready), 1);
        @(negedge clk); rst = 1'b1;
        do_load(3, 1, 1, 0);
        check("post_reset_cnt", int'(counter), 3);
        tick();
        check("post_reset_step", int'(counter), 2);

        // randomized traffic against the list-walking model
        rst = 1'b0; #1; model_reset();
        @(negedge clk); rst = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            load_valid  = ($urandom_range(0, 2) == 0);
            load_start  = 8'($urandom_range(0, 40));
            load_end    = 8'($urandom_range(0, 20));
            load_step   = 8'($urandom_range(0, 7));
            load_reload = 1'($urandom_range(0, 1));
            en          = ($urandom_range(0, 3) != 0);
            abort       = ($urandom_range(0, 29) == 0);
            #1;
            check("rnd_counter_f", int'(counter_f), model_cf());
            check("rnd_ready", int'(load_ready), (m_phase == 0 && !abort) ? 1 : 0);
            model_edge();
            tick();
            check("rnd_counter", int'(counter), m_cnt);
            check("rnd_done", int'(done), m_done);
            check("rnd_busy", int'(busy), (m_phase != 0) ? 1 : 0);
            check("rnd_at_end", int'(at_end), (m_phase == 1 && m_idx == m_last()) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
